lfsr_sng_bank: RTL

Parametrised successor to the fixed 7-bit XNOR LFSR. Adds programmable width and taps, seed load, enable, lock-up recovery and a full-period marker. It also drives a bank of comparator-based stochastic number generators (SNGs) that turn binary operands into the bitstreams consumed by the deterministic SC MAC. One LFSR is shared by all channels; each channel sees a rotated copy of the state, which decorrelates the channels.

---
 rtl/lfsr_sng_bank.sv | 104 ++++++++++
 1 files changed

// File: rtl/lfsr_sng_bank.sv
// Shared XNOR LFSR with programmable taps, seed load, lock-up recovery and a
// full-period marker, driving a bank of comparator-based stochastic number
// generators. Each channel compares its operand against a rotated copy of the
// LFSR state so the channels' bitstreams are decorrelated.
module lfsr_sng_bank #(
    parameter int               WIDTH    = 7,
    parameter logic [WIDTH-1:0] TAPS     = 7'b1100000,
    parameter int               CHANNELS = 2,
    parameter int               ROT_STEP = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [WIDTH-1:0]          seed,
    input  logic [CHANNELS*WIDTH-1:0] x,
    output logic [WIDTH-1:0]          lfsr_q,
    output logic [CHANNELS-1:0]       bs,
    output logic                      bs_valid,
    output logic                      period_done,
    output logic                      lockup
);

    // All-ones is the XNOR lock-up state; the counter wraps one below it so a
    // pulse marks every 2^WIDTH-1 enabled steps.
    localparam logic [WIDTH-1:0] ALL_ONES    = '1;
    localparam logic [WIDTH-1:0] PERIOD_LAST = ALL_ONES - 1'b1;

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    step_nxt;
    logic [CHANNELS-1:0] cmp;

    // XNOR of the tapped state bits.
    function automatic logic feedback(input logic [WIDTH-1:0] s);
        return ~^(s & TAPS);
    endfunction

    // Rotate left by amt bits (amt already reduced modulo WIDTH).
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int amt);
        logic [2*WIDTH-1:0] d;
        d = {v, v} << amt;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    // Next LFSR state, escaping lock-up by forcing the state back to zero.
    always_comb begin
        step_nxt = {lfsr_q[WIDTH-2:0], feedback(lfsr_q)};
        if (lfsr_q == ALL_ONES) begin
            step_nxt = '0;
        end
    end

    // Per-channel unsigned comparison against the rotated pre-step state.
    always_comb begin
        cmp = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cmp[k] = (x[k*WIDTH +: WIDTH] > rotl(lfsr_q, (k * ROT_STEP) % WIDTH));
        end
    end

    // LFSR state, lock-up flag and period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= '0;
            cnt         <= '0;
            period_done <= 1'b0;
            lockup      <= 1'b0;
        end else if (load) begin
            lfsr_q      <= seed;
            cnt         <= '0;
            period_done <= 1'b0;
        end else if (en) begin
            lfsr_q <= step_nxt;
            if (lfsr_q == ALL_ONES) begin
                lockup <= 1'b1;
            end
            if (cnt == PERIOD_LAST) begin
                cnt         <= '0;
                period_done <= 1'b1;
            end else begin
                cnt         <= cnt + 1'b1;
                period_done <= 1'b0;
            end
        end else begin
            period_done <= 1'b0;
        end
    end

    // SNG output register: samples on enabled steps, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bs       <= '0;
            bs_valid <= 1'b0;
        end else if (load) begin
            bs_valid <= 1'b0;
        end else if (en) begin
            bs       <= cmp;
            bs_valid <= 1'b1;
        end else begin
            bs_valid <= 1'b0;
        end
    end

endmodule
